// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, decode handshake, redirect input and halt status.
// master = fetch_unit side, slave = memory/decode/branch side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              dec_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;

  modport master (
    output imem_addr,
    output instr_out,
    output instr_pc,
    output instr_valid,
    output halted,
    input  imem_data,
    input  dec_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    input  instr_out,
    input  instr_pc,
    input  instr_valid,
    input  halted,
    output imem_data,
    output dec_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// PC/fetch control in front of a 1-cycle registered instruction memory; optional FETCH_HALT_EN stops on HALT_WORD.
// Latency: first valid word 1 cycle after reset (BOOT), zero bubbles after a redirect, 1 instr/cycle sustained.
// Backpressure: a decode stall points imem_addr back at pc_q so the same word is re-read; no skid buffer.
module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] ST_HALT = 2'd2;
`endif

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              is_halt;

  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef FETCH_HALT_EN
  assign is_halt = (bus.imem_data == HALT_WORD);
`else
  assign is_halt = 1'b0;
`endif

  // pc_q always equals the address sent on the previous edge, i.e. the PC of imem_data.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr    = pc_q;
    valid   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (bus.redirect_valid) begin
          addr = bus.redirect_pc;
          pc_d = bus.redirect_pc;
        end
      end
      ST_RUN: begin
        valid = ~bus.redirect_valid;
        if (bus.redirect_valid) begin
          addr = bus.redirect_pc;
          pc_d = bus.redirect_pc;
        end else if (bus.dec_ready) begin
          if (is_halt) begin
`ifdef FETCH_HALT_EN
            state_d = ST_HALT;
`endif
          end else begin
            addr = pc_inc;
            pc_d = pc_inc;
          end
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: begin
        if (bus.redirect_valid) begin
          addr    = bus.redirect_pc;
          pc_d    = bus.redirect_pc;
          state_d = ST_RUN;
        end
      end
`endif
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.imem_addr   = addr;
  assign bus.instr_out   = bus.imem_data;
  assign bus.instr_pc    = pc_q;
  assign bus.instr_valid = valid;
`ifdef FETCH_HALT_EN
  assign bus.halted      = (state_q == ST_HALT);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (ADDR_W = 8): directed vector table, halt sequence, then random traffic vs a PC-stream model.
module tb_fetch_unit;
  localparam int          AW        = 8;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .RESET_PC(8'h00), .HALT_WORD(HALT_WORD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [256];
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit halt_word(input logic [31:0] w);
`ifdef FETCH_HALT_EN
    return w == HALT_WORD;
`else
    return 1'b0;
`endif
  endfunction

  // Model: m_pc is the address handed to memory at the last edge, so mem[m_pc] is on imem_data.
  bit          m_known = 0;
  bit          m_boot;
  bit          m_halt;
  logic [AW-1:0] m_pc;
  bit          e_valid;
  logic [AW-1:0] e_addr;

  task automatic model_check();
    if (!m_known) return;
    e_valid = !m_boot && !m_halt && !bus.redirect_valid;
    if (bus.redirect_valid)                                 e_addr = bus.redirect_pc;
    else if (m_boot || m_halt || !bus.dec_ready)            e_addr = m_pc;
    else if (halt_word(mem[m_pc]))                          e_addr = m_pc;
    else                                                    e_addr = AW'((int'(m_pc) + 1) % (1 << AW));
    chk("valid",  {31'd0, bus.instr_valid}, {31'd0, e_valid});
    chk("pc",     {24'd0, bus.instr_pc},    {24'd0, m_pc});
    chk("addr",   {24'd0, bus.imem_addr},   {24'd0, e_addr});
    chk("halted", {31'd0, bus.halted},      {31'd0, m_halt});
    if (e_valid) chk("instr", bus.instr_out, mem[m_pc]);
  endtask

  task automatic advance();
    if (rst) begin
      m_known = 1; m_boot = 1; m_halt = 0; m_pc = '0;
    end else if (m_known) begin
      if (e_valid && bus.dec_ready && halt_word(mem[m_pc])) m_halt = 1;
      else if (bus.redirect_valid) m_halt = 0;
      m_pc   = e_addr;
      m_boot = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit rv, input logic [AW-1:0] rp, input bit rdy);
    rst = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.dec_ready      = rdy;
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    bit          rst;
    bit          rv;
    logic [7:0]  rpc;
    bit          rdy;
    bit          chk;
    bit          e_valid;
    logic [7:0]  e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit rv, logic [7:0] rp, bit rdy, bit c, bit ev, logic [7:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rp; v.rdy = rdy; v.chk = c; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    tbl.push_back(v);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
    mem[8'h30] = HALT_WORD;
    mem[8'hC7] = HALT_WORD;
    bus.redirect_valid = 0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 0;

    // rst, rv, rpc, rdy, chk, valid, pc, instr
    add(1, 0, 8'h00, 1, 0, 0, 8'h00, 32'h0);
    add(1, 0, 8'h00, 1, 1, 0, 8'h00, 32'h0);      // held in reset: BOOT outputs
    add(0, 0, 8'h00, 1, 1, 0, 8'h00, 32'h0);      // BOOT cycle
    add(0, 0, 8'h00, 1, 1, 1, 8'h00, 32'h100);
    add(0, 0, 8'h00, 1, 1, 1, 8'h01, 32'h101);
    add(0, 0, 8'h00, 1, 1, 1, 8'h02, 32'h102);
    add(0, 1, 8'h40, 1, 1, 0, 8'h03, 32'h0);      // redirect drops pc 3
    add(0, 0, 8'h00, 1, 1, 1, 8'h40, 32'h140);
    add(0, 0, 8'h00, 1, 1, 1, 8'h41, 32'h141);
    add(0, 1, 8'h05, 1, 1, 0, 8'h42, 32'h0);
    add(0, 0, 8'h00, 0, 1, 1, 8'h05, 32'h105);    // three stall cycles
    add(0, 0, 8'h00, 0, 1, 1, 8'h05, 32'h105);
    add(0, 0, 8'h00, 0, 1, 1, 8'h05, 32'h105);
    add(0, 0, 8'h00, 1, 1, 1, 8'h05, 32'h105);
    add(0, 0, 8'h00, 1, 1, 1, 8'h06, 32'h106);
    add(0, 0, 8'h00, 1, 1, 1, 8'h07, 32'h107);
    add(0, 0, 8'h00, 1, 1, 1, 8'h08, 32'h108);
    add(1, 0, 8'h00, 1, 1, 1, 8'h09, 32'h109);    // rst mid-stream
    add(0, 0, 8'h00, 1, 1, 0, 8'h00, 32'h0);
    add(0, 0, 8'h00, 1, 1, 1, 8'h00, 32'h100);
    add(0, 1, 8'hFF, 1, 1, 0, 8'h01, 32'h0);
    add(0, 0, 8'h00, 1, 1, 1, 8'hFF, 32'h1FF);    // wrap
    add(0, 0, 8'h00, 1, 1, 1, 8'h00, 32'h100);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_valid", i), {31'd0, bus.instr_valid}, {31'd0, tbl[i].e_valid});
        chk($sformatf("tbl%0d_pc", i), {24'd0, bus.instr_pc}, {24'd0, tbl[i].e_pc});
        chk($sformatf("tbl%0d_halted", i), {31'd0, bus.halted}, 32'd0);
        if (tbl[i].e_valid) chk($sformatf("tbl%0d_instr", i), bus.instr_out, tbl[i].e_instr);
      end
      advance();
    end

    // Halt word at pc 4.
    mem[4] = HALT_WORD;
    drive(1, 0, 8'h00, 1); advance();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 8'h00, 1); advance(); end
    drive(0, 0, 8'h00, 1);
    chk("halt_pc4_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("halt_pc4_pc", {24'd0, bus.instr_pc}, 32'd4);
    chk("halt_pc4_instr", bus.instr_out, HALT_WORD);
    advance();
    drive(0, 0, 8'h00, 1);
`ifdef FETCH_HALT_EN
    chk("halt_after_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_after_valid", {31'd0, bus.instr_valid}, 32'd0);
`else
    chk("halt_after_halted", {31'd0, bus.halted}, 32'd0);
    chk("halt_after_pc", {24'd0, bus.instr_pc}, 32'd5);
    chk("halt_after_valid", {31'd0, bus.instr_valid}, 32'd1);
`endif
    advance();
    drive(0, 0, 8'h00, 1); advance();
    drive(0, 1, 8'h00, 1); advance();
    drive(0, 0, 8'h00, 1);
    chk("resume_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("resume_pc", {24'd0, bus.instr_pc}, 32'd0);
    chk("resume_halted", {31'd0, bus.halted}, 32'd0);
    advance();
    mem[4] = 32'h104;

    // Random traffic against the model.
    drive(1, 0, 8'h00, 1); advance();
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          rv;
      logic [7:0]  rp;
      bit          rdy;
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 5) == 0);
      rp  = ($urandom_range(0, 3) == 0) ? 8'hFE + 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 2) != 0);
      drive(r, rv, rp, rdy);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
